// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for the Pong datapath.
// Owns the score registers and the game-flow FSM. It gates ball motion,
// issues round/match reset pulses on game_rst_n, and decodes the
// serve/pause/restart keys. Optional feature macro: PONG_AUTO_SERVE_EN
// (SERVE also falls through to PLAY after AUTO_SERVE_TICKS game ticks).
//
// state | meaning
// IDLE  | game_rst_n held low for RST_CYCLES, then go to SERVE
// SERVE | ball frozen, waiting for the serve key
// PLAY  | ball moving, scoring enabled
// HOLD  | freeze after a point for HOLD_TICKS game ticks, then round reset
// PAUSE | ball frozen by the pause key, points ignored
// OVER  | match won, only restart has effect
module pong_match_ctrl #(
    parameter int WIN_SCORE        = 7,
    parameter int HOLD_TICKS       = 32,
    parameter int RST_CYCLES       = 4,
    parameter int AUTO_SERVE_TICKS = 64
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       game_tick,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    input  logic       left_point,
    input  logic       right_point,
    output logic       motion_en,
    output logic       game_rst_n,
    output logic       serve_dir,
    output logic [2:0] scoreL,
    output logic [2:0] scoreR,
    output logic       left_win,
    output logic       right_win,
    output logic [2:0] state_dbg
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [2:0] WIN = 3'(WIN_SCORE);

    // Reject parameter sets the 3-bit score and the counters cannot represent.
    if (WIN_SCORE < 1 || WIN_SCORE > 7 || RST_CYCLES < 1 || HOLD_TICKS < 1
        || AUTO_SERVE_TICKS < 1) begin : g_param_check
        $error("pong_match_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [RW-1:0] rst_cnt, rst_cnt_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
    logic [2:0]    score_l_nxt, score_r_nxt;
    logic          serve_dir_nxt;
    logic          restart_clr;

    logic       break_flag;
    logic       key_valid, key_serve, key_pause, key_restart;
    logic [1:0] sync_l, sync_r;
    logic       prev_l, prev_r;
    logic       pt_l, pt_r, pt_l_only, pt_r_only;

    // Key decode: the byte after 0xF0 is a release code and never acts.
    assign key_valid   = scan_ready && !break_flag && (scan_code != 8'hF0);
    assign key_serve   = key_valid && (scan_code == 8'h29);
    assign key_pause   = key_valid && (scan_code == 8'h4D);
    assign key_restart = key_valid && (scan_code == 8'h2D);

    // Break-prefix tracker.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)
            break_flag <= 1'b0;
        else if (scan_ready)
            break_flag <= (scan_code == 8'hF0);
    end

    // Point inputs cross from the pixel clock: two-flop sync plus edge detect.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_l <= 2'b00;
            sync_r <= 2'b00;
            prev_l <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            sync_l <= {sync_l[0], left_point};
            sync_r <= {sync_r[0], right_point};
            prev_l <= sync_l[1];
            prev_r <= sync_r[1];
        end
    end

    assign pt_l      = sync_l[1] & ~prev_l;
    assign pt_r      = sync_r[1] & ~prev_r;
    assign pt_l_only = pt_l & ~pt_r;
    assign pt_r_only = pt_r & ~pt_l;

`ifdef PONG_AUTO_SERVE_EN
    localparam int AW = $clog2(AUTO_SERVE_TICKS + 1);
    logic [AW-1:0] auto_cnt, auto_cnt_nxt;

    // Auto-serve timer, reloaded whenever SERVE is entered.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)
            auto_cnt <= AW'(AUTO_SERVE_TICKS);
        else
            auto_cnt <= auto_cnt_nxt;
    end
`endif

    // State, counter and score registers; motion/reset outputs follow next state.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rst_cnt    <= RW'(RST_CYCLES);
            hold_cnt   <= HW'(HOLD_TICKS);
            scoreL     <= 3'd0;
            scoreR     <= 3'd0;
            serve_dir  <= 1'b0;
            left_win   <= 1'b0;
            right_win  <= 1'b0;
            motion_en  <= 1'b0;
            game_rst_n <= 1'b0;
        end else begin
            state      <= state_nxt;
            rst_cnt    <= rst_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            scoreL     <= score_l_nxt;
            scoreR     <= score_r_nxt;
            serve_dir  <= serve_dir_nxt;
            left_win   <= restart_clr ? 1'b0 : (scoreL == WIN);
            right_win  <= restart_clr ? 1'b0 : (scoreR == WIN);
            motion_en  <= (state_nxt == ST_PLAY);
            game_rst_n <= (state_nxt != ST_IDLE);
        end
    end

    // Next-state, counter and score logic.
    always_comb begin
        state_nxt     = state;
        rst_cnt_nxt   = rst_cnt;
        hold_cnt_nxt  = hold_cnt;
        score_l_nxt   = scoreL;
        score_r_nxt   = scoreR;
        serve_dir_nxt = serve_dir;
        restart_clr   = 1'b0;
`ifdef PONG_AUTO_SERVE_EN
        auto_cnt_nxt  = auto_cnt;
`endif

        case (state)
            ST_IDLE: begin
                if (rst_cnt <= RW'(1))
                    state_nxt = ST_SERVE;
                else
                    rst_cnt_nxt = rst_cnt - RW'(1);
            end
            ST_SERVE: begin
                if (key_serve)
                    state_nxt = ST_PLAY;
`ifdef PONG_AUTO_SERVE_EN
                else if (game_tick) begin
                    if (auto_cnt <= AW'(1))
                        state_nxt = ST_PLAY;
                    else
                        auto_cnt_nxt = auto_cnt - AW'(1);
                end
`endif
            end
            ST_PLAY: begin
                if (pt_l_only) begin
                    score_l_nxt   = (scoreL == WIN) ? WIN : scoreL + 3'd1;
                    serve_dir_nxt = 1'b1;
                    state_nxt     = (score_l_nxt == WIN) ? ST_OVER : ST_HOLD;
                end else if (pt_r_only) begin
                    score_r_nxt   = (scoreR == WIN) ? WIN : scoreR + 3'd1;
                    serve_dir_nxt = 1'b0;
                    state_nxt     = (score_r_nxt == WIN) ? ST_OVER : ST_HOLD;
                end else if (key_pause) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_HOLD: begin
                if (game_tick) begin
                    if (hold_cnt <= HW'(1))
                        state_nxt = ST_IDLE;
                    else
                        hold_cnt_nxt = hold_cnt - HW'(1);
                end
            end
            ST_PAUSE: begin
                if (key_pause)
                    state_nxt = ST_PLAY;
            end
            ST_OVER: begin
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Restart overrides whatever the state decided this cycle.
        if (key_restart && state != ST_IDLE) begin
            state_nxt     = ST_IDLE;
            score_l_nxt   = 3'd0;
            score_r_nxt   = 3'd0;
            serve_dir_nxt = 1'b0;
            restart_clr   = 1'b1;
        end

        // Timers reload on every state change so each entry starts fresh.
        if (state_nxt != state) begin
            rst_cnt_nxt  = RW'(RST_CYCLES);
            hold_cnt_nxt = HW'(HOLD_TICKS);
`ifdef PONG_AUTO_SERVE_EN
            auto_cnt_nxt = AW'(AUTO_SERVE_TICKS);
`endif
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with default parameters.
module tb_pong_match_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_tick = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_ready = 1'b0;
    logic       left_point = 1'b0;
    logic       right_point = 1'b0;
    logic       motion_en, game_rst_n, serve_dir, left_win, right_win;
    logic [2:0] scoreL, scoreR, state_dbg;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    localparam logic [7:0] S_IDLE = 8'd0, S_SERVE = 8'd1, S_PLAY = 8'd2,
                           S_HOLD = 8'd3, S_PAUSE = 8'd4, S_OVER = 8'd5;

    pong_match_ctrl dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .game_tick  (game_tick),
        .scan_code  (scan_code),
        .scan_ready (scan_ready),
        .left_point (left_point),
        .right_point(right_point),
        .motion_en  (motion_en),
        .game_rst_n (game_rst_n),
        .serve_dir  (serve_dir),
        .scoreL     (scoreL),
        .scoreR     (scoreR),
        .left_win   (left_win),
        .right_win  (right_win),
        .state_dbg  (state_dbg)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        scan_code  = b;
        scan_ready = 1'b1;
        step(1);
        scan_ready = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic gticks(input int n);
        repeat (n) begin
            game_tick = 1'b1;
            step(1);
            game_tick = 1'b0;
        end
    endtask

    initial begin
        // Reset values
        step(2);
        check("rst_state", 8'(state_dbg), S_IDLE);
        check("rst_game_rst_n", 8'(game_rst_n), 8'd0);
        check("rst_motion", 8'(motion_en), 8'd0);
        check("rst_scores", {2'b0, scoreL, scoreR}, 8'd0);
        check("rst_wins_dir", {5'b0, left_win, right_win, serve_dir}, 8'd0);

        // Release: game_rst_n low for exactly 4 cycles
        rst_n = 1'b1;
        step(3);
        check("idle_pulse_3", {7'b0, game_rst_n}, 8'd0);
        check("idle_state_3", 8'(state_dbg), S_IDLE);
        step(1);
        check("idle_pulse_4", 8'(game_rst_n), 8'd1);
        check("serve_state", 8'(state_dbg), S_SERVE);
        check("serve_motion", 8'(motion_en), 8'd0);

        send_byte(8'h29);
        check("play_state", 8'(state_dbg), S_PLAY);
        check("play_motion", 8'(motion_en), 8'd1);

        // Left point: 3-cycle latency
        left_point = 1'b1;
        step(2);
        check("ptl_lat2", 8'(scoreL), 8'd0);
        step(1);
        left_point = 1'b0;
        check("ptl_score", 8'(scoreL), 8'd1);
        check("ptl_dir", 8'(serve_dir), 8'd1);
        check("ptl_hold", 8'(state_dbg), S_HOLD);
        check("hold_motion", 8'(motion_en), 8'd0);

        // Hold for 32 ticks then a round reset
        gticks(31);
        check("hold_31", 8'(state_dbg), S_HOLD);
        gticks(1);
        check("hold_32", 8'(state_dbg), S_IDLE);
        check("round_rst", 8'(game_rst_n), 8'd0);
        step(3);
        check("round_pulse_3", 8'(game_rst_n), 8'd0);
        step(1);
        check("round_serve", 8'(state_dbg), S_SERVE);
        check("round_keep_l", 8'(scoreL), 8'd1);

        // Break code suppresses release, then pause/unpause
        send_byte(8'h29);
        send_byte(8'hF0);
        send_byte(8'h4D);
        check("break_play", 8'(state_dbg), S_PLAY);
        send_byte(8'h4D);
        check("pause_state", 8'(state_dbg), S_PAUSE);
        check("pause_motion", 8'(motion_en), 8'd0);
        right_point = 1'b1;
        step(4);
        right_point = 1'b0;
        step(3);
        check("pause_pt_ign", 8'(scoreR), 8'd0);
        check("pause_stays", 8'(state_dbg), S_PAUSE);
        send_byte(8'h4D);
        check("unpause", 8'(state_dbg), S_PLAY);

        // Simultaneous points are discarded
        left_point  = 1'b1;
        right_point = 1'b1;
        step(3);
        left_point  = 1'b0;
        right_point = 1'b0;
        check("both_pt", {2'b0, scoreL, scoreR}, {2'b0, 3'd1, 3'd0});
        check("both_state", 8'(state_dbg), S_PLAY);
        step(3);

        // Seven right points win the match
        for (int i = 1; i <= 7; i++) begin
            right_point = 1'b1;
            step(3);
            right_point = 1'b0;
            check($sformatf("r_score_%0d", i), 8'(scoreR), 8'(i));
            if (i == 1) check("r_dir", 8'(serve_dir), 8'd0);
            if (i < 7) begin
                gticks(32);
                step(4);
                send_byte(8'h29);
            end
        end
        check("over_state", 8'(state_dbg), S_OVER);
        check("win_lat", 8'(right_win), 8'd0);
        step(1);
        check("right_win", 8'(right_win), 8'd1);
        check("left_win", 8'(left_win), 8'd0);

        left_point = 1'b1;
        step(3);
        left_point = 1'b0;
        step(3);
        check("over_pt_ign", 8'(scoreL), 8'd1);
        send_byte(8'h29);
        check("over_serve_ign", 8'(state_dbg), S_OVER);
        check("over_motion", 8'(motion_en), 8'd0);

        send_byte(8'h2D);
        check("restart_state", 8'(state_dbg), S_IDLE);
        check("restart_scores", {2'b0, scoreL, scoreR}, 8'd0);
        check("restart_win", 8'(right_win), 8'd0);
        check("restart_rst_n", 8'(game_rst_n), 8'd0);

        // Restart beats a point in the same cycle
        step(4);
        send_byte(8'h29);
        right_point = 1'b1;
        step(3);
        right_point = 1'b0;
        check("pre_rs_score", 8'(scoreR), 8'd1);
        gticks(32);
        step(4);
        send_byte(8'h29);
        check("pre_rs_play", 8'(state_dbg), S_PLAY);
        left_point = 1'b1;
        step(2);
        send_byte(8'h2D);
        left_point = 1'b0;
        check("rs_pt_state", 8'(state_dbg), S_IDLE);
        check("rs_pt_scores", {2'b0, scoreL, scoreR}, 8'd0);
        check("rs_pt_dir", 8'(serve_dir), 8'd0);

        // Auto-serve behaviour
        step(4);
        check("as_serve", 8'(state_dbg), S_SERVE);
`ifdef PONG_AUTO_SERVE_EN
        gticks(63);
        check("as_63", 8'(state_dbg), S_SERVE);
        gticks(1);
        check("as_64", 8'(state_dbg), S_PLAY);
`else
        gticks(200);
        check("as_off_200", 8'(state_dbg), S_SERVE);
`endif

        // Asynchronous reset mid-operation
        send_byte(8'h29);
        #5;
        rst_n = 1'b0;
        #2;
        check("async_state", 8'(state_dbg), S_IDLE);
        check("async_out", {5'b0, motion_en, game_rst_n, serve_dir}, 8'd0);
        step(1);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
